// File: rtl/cubic_sweep_src.sv
// Sweep source for the combinational cubic evaluator plus a 2-entry first-word-fall-through result FIFO.
// Build macro CUBIC_SWEEP_OVF_SKIP_EN drops out-of-range (|x| >= 2.0) samples instead of flagging them.
module cubic_sweep_src #(
  parameter int unsigned STEP      = 8,
  parameter int unsigned N_SAMPLES = 128,
  parameter logic [9:0]  START_VAL = 10'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [9:0] cubic_in,
  input  logic [9:0] cubic_out,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [9:0] m_in,
  output logic [9:0] m_out,
  output logic       m_ovf,
  output logic       m_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       ovf;
    logic       last;
  } entry_t;

  localparam logic [9:0]  STEP_C   = 10'(STEP);
  localparam logic [10:0] LAST_IDX = 11'(N_SAMPLES - 1);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [9:0]  x_q, x_d;
  logic [10:0] idx_q, idx_d;
  entry_t      fifo_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        sample_ovf;
  logic        sample_last;
  logic        pop;
  logic        capture;
  logic        push;
  entry_t      wr_entry;
  entry_t      head;

  // -256 (0x300) is the only in-range-looking code whose top two bits agree yet is still out of range.
  always_comb begin
    sample_ovf  = (x_q[9] ^ x_q[8]) | (x_q == 10'h300);
    sample_last = (idx_q == LAST_IDX);
    pop         = (cnt_q != 2'd0) & m_ready;
    capture     = (state_q == RUN) & ((cnt_q != 2'd2) | pop);
`ifdef CUBIC_SWEEP_OVF_SKIP_EN
    push        = capture & ~sample_ovf;
    wr_entry    = '{x: x_q, y: cubic_out, ovf: 1'b0, last: sample_last};
`else
    push        = capture;
    wr_entry    = '{x: x_q, y: cubic_out, ovf: sample_ovf, last: sample_last};
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Start is registered for one cycle so the first capture lands two edges after acceptance.
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    x_d     = x_q;
    idx_d   = idx_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = RUN;
          x_d     = START_VAL;
          idx_d   = '0;
        end else if (start) begin
          pend_d = 1'b1;
        end
      end
      RUN: begin
        if (capture) begin
          idx_d = idx_q + 11'd1;
          if (sample_last) begin
            state_d = DRAIN;
          end else begin
            x_d = x_q + STEP_C;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 2'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy = pend_q | (state_q == RUN) | ((state_q == DRAIN) & ~done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      x_q      <= '0;
      idx_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      x_q      <= x_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= wr_entry;
      end
    end
  end

  // Beat fields are forced to zero whenever the FIFO is empty.
  always_comb begin
    head     = fifo_q[rd_ptr_q];
    m_valid  = (cnt_q != 2'd0);
    m_in     = m_valid ? head.x : '0;
    m_out    = m_valid ? head.y : '0;
    m_ovf    = m_valid & head.ovf;
    m_last   = m_valid & head.last;
    cubic_in = x_q;
  end

endmodule

// File: tb/tb_cubic_sweep_src.sv
// Scoreboard bench for cubic_sweep_src: models cubic as y = 5x + 64 (mod 2^10) and checks every beat,
// latency, backpressure, ignored starts and mid-sweep reset.
module tb_cubic_sweep_src;

  localparam int         STEP      = 8;
  localparam int         N_SAMPLES = 128;
  localparam logic [9:0] START_VAL = 10'd0;
`ifdef CUBIC_SWEEP_OVF_SKIP_EN
  localparam int EXP_BEATS = 63;
  localparam int EXP_OVF   = 0;
`else
  localparam int EXP_BEATS = 128;
  localparam int EXP_OVF   = 65;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       ovf;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       m_ready;
  logic [9:0] cubic_in;
  logic [9:0] cubic_out;
  logic       m_valid;
  logic [9:0] m_in;
  logic [9:0] m_out;
  logic       m_ovf;
  logic       m_last;
  logic       busy;
  logic       done;

  beat_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  int    beatCount;
  int    ovfCount;
  int    expBeats;

  always #5 clk = ~clk;

  function automatic logic [9:0] cubicModel(input logic [9:0] x);
    logic [9:0] r;
    r = x * 10'd5 + 10'd64;
    return r;
  endfunction

  assign cubic_out = cubicModel(cubic_in);

  cubic_sweep_src #(
    .STEP(STEP),
    .N_SAMPLES(N_SAMPLES),
    .START_VAL(START_VAL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cubic_in(cubic_in),
    .cubic_out(cubic_out),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_in(m_in),
    .m_out(m_out),
    .m_ovf(m_ovf),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_m_valid"},  32'(m_valid),  32'd0);
    check({tag, "_m_in"},     32'(m_in),     32'd0);
    check({tag, "_m_out"},    32'(m_out),    32'd0);
    check({tag, "_m_ovf"},    32'(m_ovf),    32'd0);
    check({tag, "_m_last"},   32'(m_last),   32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_cubic_in"}, 32'(cubic_in), 32'd0);
  endtask

  // Fills the scoreboard for one sweep, pulses start and checks the two-edge capture latency.
  task automatic applyStimulus();
    logic [9:0] x;
    beat_t      b;
    int         sx;
    expQ.delete();
    x = START_VAL;
    for (int i = 0; i < N_SAMPLES; i++) begin
      sx     = int'($signed(x));
      b.x    = x;
      b.y    = cubicModel(x);
      b.ovf  = (sx >= 256) || (sx <= -256);
      b.last = (i == N_SAMPLES - 1);
`ifdef CUBIC_SWEEP_OVF_SKIP_EN
      if (!b.ovf) expQ.push_back(b);
`else
      expQ.push_back(b);
`endif
      x = x + 10'(STEP);
    end
    expBeats = expQ.size();
    m_ready  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("valid_edge_k", 32'(m_valid), 32'd0);
    @(negedge clk);
    #1;
    check("valid_edge_k1", 32'(m_valid), 32'd0);
    check("cubic_in_load", 32'(cubic_in), 32'(START_VAL));
    @(negedge clk);
    #1;
    check("valid_edge_k2", 32'(m_valid), 32'd1);
    check("cubic_in_step", 32'(cubic_in), 32'(10'(START_VAL + 10'(STEP))));
  endtask

  task automatic checkOutput();
    beat_t e;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=m_in %0h expected=no_beat", m_in);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("m_in",   32'(m_in),   32'(e.x));
      check("m_out",  32'(m_out),  32'(e.y));
      check("m_ovf",  32'(m_ovf),  32'(e.ovf));
      check("m_last", 32'(m_last), 32'(e.last));
      if (beatCount == 0) check("beat0_m_out", 32'(m_out), 32'h040);
    end
    if (m_ovf === 1'b1) ovfCount++;
    beatCount++;
  endtask

  // Consumes one sweep; optional stall after beat stallAt, stray start at beat busyStartAt,
  // reset at beat abortAt, and a start coincident with done.
  task automatic runSweep(input int stallAt, input int busyStartAt, input int abortAt, input bit startAtDone);
    int  cyc;
    int  stallLeft;
    int  stallCyc;
    int  lastHs;
    bit  finished;
    bit  busyPulsed;
    cyc = 0; stallLeft = 0; stallCyc = 0; lastHs = -10;
    finished = 1'b0; busyPulsed = 1'b0;
    beatCount = 0; ovfCount = 0;
    while (!finished && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (stallLeft > 0) begin
        m_ready = 1'b0;
        stallLeft--;
        stallCyc++;
      end else begin
        m_ready = 1'b1;
      end
      if (busyStartAt >= 0 && beatCount == busyStartAt && !busyPulsed) begin
        start      = 1'b1;
        busyPulsed = 1'b1;
      end
      #1;
      if (abortAt >= 0 && beatCount == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        expQ.delete();
        m_ready = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (!m_ready) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        if (expQ.size() > 0) begin
          check("stall_m_in",  32'(m_in),  32'(expQ[0].x));
          check("stall_m_out", 32'(m_out), 32'(expQ[0].y));
        end
        if (stallCyc >= 2) check("stall_cubic_in", 32'(cubic_in), 32'(10'(START_VAL + 10'(6 * STEP))));
      end
      if (done) begin
        check("done_after_last_hs", 32'(cyc - lastHs), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("beat_total", 32'(beatCount), 32'(expBeats));
        check("beat_total_fixed", 32'(beatCount), 32'(EXP_BEATS));
        check("ovf_total", 32'(ovfCount), 32'(EXP_OVF));
        check("queue_drained", 32'(expQ.size()), 32'd0);
        if (startAtDone) start = 1'b1;
        finished = 1'b1;
      end else if (m_valid && m_ready) begin
        checkOutput();
        lastHs = cyc;
        if (beatCount == stallAt + 1) stallLeft = 5;
      end
    end
    check("sweep_completed", 32'(finished), 32'd1);
    @(negedge clk);
    start   = 1'b0;
    m_ready = 1'b0;
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    m_ready = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus();
    runSweep(-1, 20, -1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(m_valid), 32'd0);
    end

    applyStimulus();
    runSweep(3, -1, -1, 1'b0);

    applyStimulus();
    runSweep(-1, -1, 40, 1'b0);

    applyStimulus();
    runSweep(-1, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
